// File: rtl/ex_stage_pipe.sv
// Registered execute stage: operand forwarding, ALU with control decode, branch-target
// adder, an iterative shift-add multiplier, and an EX/MEM output register with valid/ready.
module ex_stage_pipe #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MUL_BPC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  input  logic [10:0]       opcode,
  input  logic              alu_src,
  input  logic [1:0]        alu_op,
  input  logic [1:0]        fwd_sel_a,
  input  logic [1:0]        fwd_sel_b,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic [DATA_W-1:0] fwd_wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic              out_zero,
  output logic [DATA_W-1:0] out_branch_target,
  output logic [DATA_W-1:0] out_store_data,
  output logic              busy
);

  localparam int unsigned MUL_ITERS = DATA_W / MUL_BPC;
  localparam int unsigned CNT_W     = $clog2(MUL_ITERS + 1);

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_ORR,
    ALU_PASSB,
    ALU_MUL
  } alu_fn_e;

  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_res;
  logic [DATA_W-1:0] w_branch_target;
  logic [DATA_W-1:0] w_pp;
  alu_fn_e           w_alu_fn;
  logic              w_is_mul;
  logic              w_accept;
  logic              w_out_free;
  logic              w_mul_done;
  logic              w_mul_step;
  logic              w_mul_load;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic              r_out_zero;
  logic [DATA_W-1:0] r_out_bt;
  logic [DATA_W-1:0] r_out_sd;

  logic              r_busy;
  logic [CNT_W-1:0]  r_mul_cnt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mul_bt;
  logic [DATA_W-1:0] r_mul_sd;

  // Operand forwarding
  always_comb begin
    case (fwd_sel_a)
      2'b01:   w_op_a = fwd_mem_data;
      2'b10:   w_op_a = fwd_wb_data;
      default: w_op_a = rd_data1;
    endcase
    case (fwd_sel_b)
      2'b01:   w_op_b = fwd_mem_data;
      2'b10:   w_op_b = fwd_wb_data;
      default: w_op_b = rd_data2;
    endcase
  end

  assign w_alu_b = alu_src ? imm : w_op_b;

  // ALU control decode
  always_comb begin
    w_alu_fn = ALU_ADD;
    case (alu_op)
      2'b01: w_alu_fn = ALU_PASSB;
      2'b10: begin
        case (opcode)
          OPC_ADD: w_alu_fn = ALU_ADD;
          OPC_SUB: w_alu_fn = ALU_SUB;
          OPC_AND: w_alu_fn = ALU_AND;
          OPC_ORR: w_alu_fn = ALU_ORR;
          OPC_MUL: w_alu_fn = ALU_MUL;
          default: w_alu_fn = ALU_ADD;
        endcase
      end
      default: w_alu_fn = ALU_ADD;
    endcase
  end

  assign w_is_mul = (w_alu_fn == ALU_MUL);

  // Single-cycle ALU; MUL goes through the iterative datapath instead
  always_comb begin
    case (w_alu_fn)
      ALU_SUB:   w_alu_res = w_op_a - w_alu_b;
      ALU_AND:   w_alu_res = w_op_a & w_alu_b;
      ALU_ORR:   w_alu_res = w_op_a | w_alu_b;
      ALU_PASSB: w_alu_res = w_alu_b;
      default:   w_alu_res = w_op_a + w_alu_b;
    endcase
  end

  assign w_branch_target = pc + (imm << 2);

  assign in_ready   = rst_n & ~flush & ~r_busy & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & in_ready;
  assign w_out_free = ~r_out_valid | out_ready;
  assign w_mul_done = r_busy & (r_mul_cnt == CNT_W'(MUL_ITERS));
  assign w_mul_step = r_busy & ~w_mul_done;
  assign w_mul_load = w_mul_done & w_out_free & ~flush;

  // Partial product for the MUL_BPC low multiplier bits of this iteration
  always_comb begin
    w_pp = '0;
    for (int unsigned j = 0; j < MUL_BPC; j++) begin
      if (r_mplier[j]) w_pp = w_pp + (r_mcand << j);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_mul_cnt <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_mul_bt  <= '0;
      r_mul_sd  <= '0;
    end else if (flush) begin
      r_busy    <= 1'b0;
      r_mul_cnt <= '0;
    end else if (w_accept && w_is_mul) begin
      r_busy    <= 1'b1;
      r_mul_cnt <= '0;
      r_mcand   <= w_op_a;
      r_mplier  <= w_alu_b;
      r_acc     <= '0;
      r_mul_bt  <= w_branch_target;
      r_mul_sd  <= w_op_b;
    end else if (w_mul_step) begin
      r_acc     <= r_acc + w_pp;
      r_mcand   <= r_mcand << MUL_BPC;
      r_mplier  <= r_mplier >> MUL_BPC;
      r_mul_cnt <= r_mul_cnt + CNT_W'(1);
    end else if (w_mul_load) begin
      r_busy    <= 1'b0;
      r_mul_cnt <= '0;
    end
  end

  // EX/MEM output register; data holds whenever nothing new is loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_zero   <= 1'b0;
      r_out_bt     <= '0;
      r_out_sd     <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_alu_res;
      r_out_zero   <= (w_alu_res == '0);
      r_out_bt     <= w_branch_target;
      r_out_sd     <= w_op_b;
    end else if (w_mul_load) begin
      r_out_valid  <= 1'b1;
      r_out_result <= r_acc;
      r_out_zero   <= (r_acc == '0);
      r_out_bt     <= r_mul_bt;
      r_out_sd     <= r_mul_sd;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid         = r_out_valid;
  assign out_alu_result    = r_out_result;
  assign out_zero          = r_out_zero;
  assign out_branch_target = r_out_bt;
  assign out_store_data    = r_out_sd;
  assign busy              = r_busy;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: two instances (1 and 4 multiplier bits per cycle)
// share one stimulus stream; expected values are hand-computed constants.
module tb_ex_stage_pipe;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] rd_data1, rd_data2, pc, imm, fwd_mem_data, fwd_wb_data;
  logic [10:0] opcode;
  logic        alu_src;
  logic [1:0]  alu_op, fwd_sel_a, fwd_sel_b;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, out_zero, busy;
  logic [63:0] out_alu_result, out_branch_target, out_store_data;
  logic        in_ready4, out_valid4, out_zero4, busy4;
  logic [63:0] out_alu_result4, out_branch_target4, out_store_data4;

  int total = 0;
  int bad   = 0;

  ex_stage_pipe #(.DATA_W(64), .MUL_BPC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .pc(pc), .imm(imm), .opcode(opcode),
    .alu_src(alu_src), .alu_op(alu_op), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_result(out_alu_result),
    .out_zero(out_zero), .out_branch_target(out_branch_target),
    .out_store_data(out_store_data), .busy(busy)
  );

  ex_stage_pipe #(.DATA_W(64), .MUL_BPC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .pc(pc), .imm(imm), .opcode(opcode),
    .alu_src(alu_src), .alu_op(alu_op), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready), .out_alu_result(out_alu_result4),
    .out_zero(out_zero4), .out_branch_target(out_branch_target4),
    .out_store_data(out_store_data4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] pcv,
                          input logic [63:0] immv, input logic [10:0] opc,
                          input logic [1:0] aop, input logic src,
                          input logic [1:0] fa, input logic [1:0] fb);
    rd_data1  = a;
    rd_data2  = b;
    pc        = pcv;
    imm       = immv;
    opcode    = opc;
    alu_op    = aop;
    alu_src   = src;
    fwd_sel_a = fa;
    fwd_sel_b = fb;
    in_valid  = 1'b1;
  endtask

  initial begin
    int lat1, lat4, viol, stall_bad;
    logic [63:0] res1, res4, bt1, sd1;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    rd_data1 = '0; rd_data2 = '0; pc = '0; imm = '0; opcode = '0;
    alu_src = 1'b0; alu_op = 2'b00; fwd_sel_a = 2'b00; fwd_sel_b = 2'b00;
    fwd_mem_data = '0; fwd_wb_data = '0;

    // Reset and release
    repeat (3) @(posedge clk);
    #1;
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    #1;
    check1("rel_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    check1("rel_out_valid", out_valid, 1'b0);

    // SUB 5-5
    drive_op(64'd5, 64'd5, 64'd0, 64'd0, OPC_SUB, 2'b10, 1'b0, 2'b00, 2'b00);
    @(posedge clk); #1; in_valid = 1'b0;
    check1("sub_valid", out_valid, 1'b1);
    check("sub_result", out_alu_result, 64'd0);
    check1("sub_zero", out_zero, 1'b1);

    // ORR F0|0F
    drive_op(64'hF0, 64'h0F, 64'd0, 64'd0, OPC_ORR, 2'b10, 1'b0, 2'b00, 2'b00);
    @(posedge clk); #1; in_valid = 1'b0;
    check("orr_result", out_alu_result, 64'hFF);
    check1("orr_zero", out_zero, 1'b0);

    // Forwarded A from MEM + imm; store data forwarded from WB
    fwd_mem_data = 64'd7; fwd_wb_data = 64'hABCD;
    drive_op(64'd100, 64'h55, 64'd0, 64'd3, OPC_ADD, 2'b00, 1'b1, 2'b01, 2'b10);
    @(posedge clk); #1; in_valid = 1'b0;
    check("fwd_add_result", out_alu_result, 64'd10);
    check("fwd_store_data", out_store_data, 64'hABCD);

    // Branch target with negative immediate
    drive_op(64'h20, 64'h0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFE, OPC_ADD, 2'b00, 1'b1, 2'b00, 2'b00);
    @(posedge clk); #1; in_valid = 1'b0;
    check("br_target", out_branch_target, 64'hFF8);
    check("br_addi_result", out_alu_result, 64'h1E);

    // CBZ pass-B with B=0
    drive_op(64'h99, 64'h0, 64'd0, 64'd0, OPC_ADD, 2'b01, 1'b0, 2'b00, 2'b00);
    @(posedge clk); #1; in_valid = 1'b0;
    check("cbz_result", out_alu_result, 64'd0);
    check1("cbz_zero", out_zero, 1'b1);

    // Unknown R-type opcode decodes as ADD
    drive_op(64'd3, 64'd4, 64'd0, 64'd0, 11'b00000000000, 2'b10, 1'b0, 2'b00, 2'b00);
    @(posedge clk); #1; in_valid = 1'b0;
    check("rdef_add_result", out_alu_result, 64'd7);

    // AND, then asynchronous reset mid-cycle
    drive_op(64'hF0, 64'h3C, 64'h40, 64'd1, OPC_AND, 2'b10, 1'b0, 2'b00, 2'b00);
    @(posedge clk); #1; in_valid = 1'b0;
    check("and_result", out_alu_result, 64'h30);
    #2 rst_n = 1'b0;
    #1;
    check1("arst_out_valid", out_valid, 1'b0);
    check("arst_result", out_alu_result, 64'd0);
    check("arst_bt", out_branch_target, 64'd0);
    check("arst_sd", out_store_data, 64'd0);
    check1("arst_in_ready", in_ready, 1'b0);
    #1 rst_n = 1'b1;
    #1;
    check1("arst_rel_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // MUL all-ones x 3 on both instances
    drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h2000, 64'd1, OPC_MUL, 2'b10, 1'b0, 2'b00, 2'b00);
    @(posedge clk); #1; in_valid = 1'b0;
    check1("mul_busy_e0", busy, 1'b1);
    check1("mul_in_ready_e0", in_ready, 1'b0);
    lat1 = 0; lat4 = 0; viol = 0;
    res1 = '0; res4 = '0; bt1 = '0; sd1 = '0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (lat1 == 0 && out_valid) begin
        lat1 = k; res1 = out_alu_result; bt1 = out_branch_target; sd1 = out_store_data;
      end
      if (lat4 == 0 && out_valid4) begin
        lat4 = k; res4 = out_alu_result4;
      end
      if (lat1 == 0 && (in_ready || !busy)) viol++;
    end
    check("mul1_latency", 64'(lat1), 64'd65);
    check("mul4_latency", 64'(lat4), 64'd17);
    check("mul1_result", res1, 64'hFFFF_FFFF_FFFF_FFFD);
    check("mul4_result", res4, 64'hFFFF_FFFF_FFFF_FFFD);
    check("mul_busy_window", 64'(viol), 64'd0);
    check("mul_bt", bt1, 64'h2004);
    check("mul_sd", sd1, 64'd3);

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    drive_op(64'd11, 64'd22, 64'd0, 64'd0, OPC_ADD, 2'b00, 1'b0, 2'b00, 2'b00);
    @(posedge clk); #1;
    drive_op(64'd1, 64'd2, 64'd0, 64'd0, OPC_ORR, 2'b10, 1'b0, 2'b00, 2'b00);
    check("bp_first", out_alu_result, 64'd33);
    check1("bp_in_ready", in_ready, 1'b0);
    stall_bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (!(out_valid && out_alu_result == 64'd33 && !in_ready && !out_zero)) stall_bad++;
    end
    check("bp_stable", 64'(stall_bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    check1("bp_swap_valid", out_valid, 1'b1);
    check("bp_swap_result", out_alu_result, 64'd3);

    // Streamed ADDs, one result per cycle
    for (int i = 0; i < 4; i++) begin
      drive_op(64'(i * 10), 64'd1, 64'd0, 64'd0, OPC_ADD, 2'b00, 1'b0, 2'b00, 2'b00);
      @(posedge clk); #1;
      check("stream_result", out_alu_result, 64'(i * 10 + 1));
      check1("stream_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check1("stream_drained", out_valid, 1'b0);

    // Flush at iteration 10 of a MUL, then flush with a pending ADD, then a normal ADD
    drive_op(64'd5, 64'd7, 64'd0, 64'd0, OPC_MUL, 2'b10, 1'b0, 2'b00, 2'b00);
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check1("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    check1("flush_busy", busy, 1'b0);
    check1("flush_busy4", busy4, 1'b0);
    check1("flush_out_valid", out_valid, 1'b0);
    drive_op(64'd9, 64'd9, 64'd0, 64'd0, OPC_ADD, 2'b00, 1'b0, 2'b00, 2'b00);
    @(posedge clk); #1;
    check1("flush_drop_valid", out_valid, 1'b0);
    flush = 1'b0;
    drive_op(64'd2, 64'd2, 64'd0, 64'd0, OPC_ADD, 2'b00, 1'b0, 2'b00, 2'b00);
    @(posedge clk); #1; in_valid = 1'b0;
    check1("post_flush_valid", out_valid, 1'b1);
    check("post_flush_result", out_alu_result, 64'd4);
    repeat (70) @(posedge clk);
    #1;
    check1("post_flush_no_ghost", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised, registered execute stage for the pipelined core. It provides operand forwarding, the ALU and ALU-control decode, a branch-target adder, and an iterative multi-cycle multiplier. Results go into an EX/MEM output register under a valid/ready handshake. The block sits between the ID/EX register and the memory stage, and it back-pressures decode while a multiply is in progress.

## Interface
Parameters:
- `DATA_W`, 64: datapath width; must be a multiple of `MUL_BPC`.
- `MUL_BPC`, 1: multiplier bits retired per cycle; allowed values are 1, 2, 4 or 8.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset. **Asynchronous assert, active-low.**
- `in_valid` in 1: ID/EX presents an operation.
- `in_ready` out 1: stage can accept; transfer occurs when `in_valid && in_ready`.
- `rd_data1` in `DATA_W`: register operand A.
- `rd_data2` in `DATA_W`: register operand B.
- `pc` in `DATA_W`: PC of the instruction.
- `imm` in `DATA_W`: sign-extended immediate.
- `opcode` in 11: instruction opcode field.
- `alu_src` in 1: 1 selects `imm` as ALU input B.
- `alu_op` in 2: 00 ADD, 01 PASS-B (CBZ), 10 R-type decode, 11 ADD.
- `fwd_sel_a` in 2: forwarding select for A: 00 register, 01 `fwd_mem_data`, 10 `fwd_wb_data`, 11 register.
- `fwd_sel_b` in 2: forwarding select for B, same encoding as `fwd_sel_a`.
- `fwd_mem_data` in `DATA_W`: forwarded value from MEM.
- `fwd_wb_data` in `DATA_W`: forwarded value from WB.
- `flush` in 1: synchronous kill of in-flight and output contents.
- `out_valid` out 1: EX/MEM register holds a result.
- `out_ready` in 1: MEM consumes the output when `out_valid && out_ready`.
- `out_alu_result` out `DATA_W`: registered ALU or multiplier result.
- `out_zero` out 1: registered; 1 when `out_alu_result == 0`.
- `out_branch_target` out `DATA_W`: registered `pc + (imm << 2)`, truncated to `DATA_W`.
- `out_store_data` out `DATA_W`: registered forwarded B; this is never `imm`.
- `busy` out 1: multiplier is occupied.

## Operation
- Forwarding is applied first. The selected A and B feed the ALU. Forwarded B feeds `out_store_data`, and `alu_src` then chooses between forwarded B and `imm` for ALU input B.
- R-type decode (`alu_op` = 10):
  - `10001011000` ADD
  - `11001011000` SUB
  - `10001010000` AND
  - `10101010000` ORR
  - `10011011000` MUL
  - Any other opcode decodes as ADD.
- Arithmetic is modulo 2^`DATA_W`. MUL produces the low `DATA_W` bits of the product; signedness does not affect these bits.
- Single-cycle ops (everything except MUL) are computed combinationally and loaded into the output register on the accept edge.
- MUL uses an iterative shift-add datapath:
  - The accept edge loads the multiplicand, multiplier and a zeroed accumulator, and sets `busy`.
  - Each following edge retires `MUL_BPC` multiplier bits.
  - After N = `DATA_W`/`MUL_BPC` iterations the product is complete.
  - The product loads into the output register on the first edge where that register is free (empty, or being consumed that edge). `busy` clears on that same edge.
  - `pc`, `imm` and forwarded B are captured at accept for the branch-target and store-data fields.
- `in_ready = rst_n && !flush && !busy && (!out_valid || out_ready)`.
- While `out_valid && !out_ready`, all `out_*` signals hold stable.
- `flush`, synchronous and highest priority:
  - clears `out_valid` and `busy`, aborting any multiply;
  - holds `in_ready` low, so no transfer occurs that cycle;
  - leaves data registers undefined-but-stable; only the valid bits matter.
- Reset (`rst_n` low), asynchronous: `out_valid`=0, `busy`=0, `out_alu_result`=0, `out_zero`=0, `out_branch_target`=0, `out_store_data`=0, iteration counter=0. `in_ready` is 0 while `rst_n` is low. Reset mid-multiply discards the operation.

## Timing
- Single-cycle op accepted at edge E0: `out_valid`=1 after E0. Back-to-back throughput is 1 per cycle when `out_ready`=1.
- MUL accepted at E0: iterations occur on E1..EN, and the output loads at E(N+1) if free, else on the first later free edge.
  - Latency is N+1 edges: 65 for `DATA_W`=64, `MUL_BPC`=1; 17 for `MUL_BPC`=4.
- `busy` is 1 from after E0 up to and including the cycle before the output load. `in_ready` is 0 throughout that window.
- A simultaneous output consume and new accept in the same cycle is legal. The output register takes the new result and `out_valid` stays 1.
- `flush` together with `in_valid` drops the input. `flush` during the completion edge drops the product.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 asynchronously mid-cycle.
  - Required response: all outputs go to 0 immediately, and `in_ready`=0.
  - Stimulus: release reset.
  - Required response: `in_ready`=1 after release.
- ALU ops with forwarding (`DATA_W`=64):
  - SUB with A=5, B=5 → `out_alu_result`=0, `out_zero`=1.
  - ORR of `0xF0`|`0x0F` → `0xFF`.
  - `fwd_sel_a`=01 with `fwd_mem_data`=7 and ADD with `imm`=3, `alu_src`=1 → 10.
- Branch and store fields:
  - `pc`=`0x1000`, `imm`=-2 → `out_branch_target`=`0xFF8`.
  - CBZ (`alu_op`=01) with B=0 → `out_zero`=1.
  - A store with `alu_src`=1 → `out_store_data` equals forwarded B.
- MUL:
  - `0xFFFF_FFFF_FFFF_FFFF` × 3 with `MUL_BPC`=1 → result `0xFFFF_FFFF_FFFF_FFFD`, `out_valid` exactly 65 edges after accept, `in_ready`=0 throughout.
  - Repeat with `MUL_BPC`=4 → 17 edges.
- Back-pressure:
  - Hold `out_ready`=0 for 5 cycles with a valid result → outputs stable, `in_ready`=0, no loss.
  - Drive streamed ADDs with `out_ready`=1 → one result per cycle.
- Flush:
  - Assert `flush` at iteration 10 of a MUL → `busy`=0 and `out_valid`=0 next cycle, and the next ADD completes normally.
